// File: rtl/mdu_mul_seq_if.sv
// Handshake and operand/result bundle between the MDU controller and the
// iterative multiplier. The controller side is the master.
interface mdu_mul_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        clr;
  logic [63:0] z;
  logic        busy;
  logic        over;

  modport master (
    output start, is_signed, a, b, clr,
    input  z, busy, over
  );

  modport slave (
    input  start, is_signed, a, b, clr,
    output z, busy, over
  );
endinterface

// File: rtl/mdu_mul_seq.sv
// Iterative 32x32 multiplier with a start/busy/over handshake.
// The operand magnitudes go through a radix-2 shift-add over 32 cycles.
// The sign is then applied and the 64-bit {hi,lo} product is presented
// together with a one-cycle over strobe.
module mdu_mul_seq (
  input  logic         clk,
  input  logic         reset_n,
  mdu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] mcand_reg, mcand_next;
  logic [31:0] mplr_reg, mplr_next;
  logic [63:0] prod_reg, prod_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        neg_reg, neg_next;
  logic [63:0] z_reg, z_next;

  // Operand magnitudes. These are 32-bit unsigned, so 0x80000000 maps onto itself.
  logic [31:0] a_mag, b_mag;
  assign a_mag = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign b_mag = bus.b[31] ? (32'd0 - bus.b) : bus.b;

  // One shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the 65-bit result right by one.
  logic [32:0] sum;
  logic [63:0] prod_step;
  assign sum       = {1'b0, prod_reg[63:32]} + {1'b0, (mplr_reg[0] ? mcand_reg : 32'd0)};
  assign prod_step = {sum, prod_reg[31:1]};

  // Outputs come straight from registers, so there is no input-to-output path.
  assign bus.busy = (state_reg == CALC);
  assign bus.over = (state_reg == DONE);
  assign bus.z    = z_reg;

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      mcand_reg <= 32'd0;
      mplr_reg  <= 32'd0;
      prod_reg  <= 64'd0;
      cnt_reg   <= 5'd0;
      neg_reg   <= 1'b0;
      z_reg     <= 64'd0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      mplr_reg  <= mplr_next;
      prod_reg  <= prod_next;
      cnt_reg   <= cnt_next;
      neg_reg   <= neg_next;
      z_reg     <= z_next;
    end
  end

  // Next-state and datapath logic. clr overrides everything and leaves z intact.
  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    mplr_next  = mplr_reg;
    prod_next  = prod_reg;
    cnt_next   = cnt_reg;
    neg_next   = neg_reg;
    z_next     = z_reg;

    case (state_reg)
      IDLE, DONE: begin
        // DONE lasts one cycle. A start seen there chains straight into the next op.
        state_next = IDLE;
        if (bus.start) begin
          state_next = CALC;
          mcand_next = bus.is_signed ? a_mag : bus.a;
          mplr_next  = bus.is_signed ? b_mag : bus.b;
          neg_next   = bus.is_signed & (bus.a[31] ^ bus.b[31]);
          prod_next  = 64'd0;
          cnt_next   = 5'd0;
        end
      end
      CALC: begin
        prod_next = prod_step;
        mplr_next = mplr_reg >> 1;
        cnt_next  = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          state_next = DONE;
          z_next     = neg_reg ? (64'd0 - prod_step) : prod_step;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.clr) begin
      state_next = IDLE;
      z_next     = z_reg;
    end
  end

endmodule

// File: tb/tb_mdu_mul_seq.sv
// Self-checking bench for mdu_mul_seq. It uses directed operations with
// hand-computed products. A cycle-level reference model runs alongside and
// is compared against the DUT on every falling edge.
module tb_mdu_mul_seq;

  logic clk;
  logic reset_n;
  mdu_mul_seq_if bus_if ();

  mdu_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact product from plain arithmetic: extend both operands to 64 bits and multiply.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Reference model. An accepted op produces its result 32 edges later.
  // clr abandons the op, and z only changes on completion.
  logic        m_busy, m_over;
  logic [63:0] m_z, m_res;
  int          m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_over <= 1'b0;
      m_z    <= 64'd0;
      m_res  <= 64'd0;
      m_left <= 0;
    end else if (bus_if.clr) begin
      m_busy <= 1'b0;
      m_over <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_over <= 1'b1;
        m_z    <= m_res;
      end
      m_left <= m_left - 1;
    end else begin
      m_over <= 1'b0;
      if (bus_if.start) begin
        m_busy <= 1'b1;
        m_left <= 32;
        m_res  <= ref_prod(bus_if.a, bus_if.b, bus_if.is_signed);
      end
    end
  end

  // Compare process: runs every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cyc busy", {63'd0, bus_if.busy}, {63'd0, m_busy});
    check("cyc over", {63'd0, bus_if.over}, {63'd0, m_over});
    check("cyc z", bus_if.z, m_z);
    check("cyc over&busy", {63'd0, bus_if.over & bus_if.busy}, 64'd0);
  end

  // Present one start cycle. On return, the accepting edge has just passed.
  task automatic do_start(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    bus_if.a         = x;
    bus_if.b         = y;
    bus_if.is_signed = s;
    bus_if.start     = 1'b1;
    @(negedge clk);
    bus_if.start     = 1'b0;
  endtask

  // Wait (bounded) for over. n0 is the number of edges already elapsed since acceptance.
  task automatic wait_over(input logic [63:0] exp, input string name, input int n0);
    int n;
    n = n0;
    while (bus_if.over !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " z"}, bus_if.z, exp);
    $display("op %-12s z=%h expected=%h after %0d cycles", name, bus_if.z, exp, n);
  endtask

  initial begin
    bit seen;
    reset_n          = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.is_signed = 1'b0;
    bus_if.a         = 32'd0;
    bus_if.b         = 32'd0;
    bus_if.clr       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, bus_if.busy}, 64'd0);
    check("reset over", {63'd0, bus_if.over}, 64'd0);
    check("reset z", bus_if.z, 64'd0);
    reset_n = 1'b1;

    // Unsigned max, then z must hold through idle cycles.
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_over(64'hFFFF_FFFE_0000_0001, "umax", 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold z", bus_if.z, 64'hFFFF_FFFE_0000_0001);
    end

    // Signed corners.
    do_start(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_over(64'hFFFF_FFFF_FFFF_FFF1, "-3x5", 0);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_over(64'h0000_0000_0000_0001, "-1x-1", 0);
    do_start(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_over(64'h4000_0000_0000_0000, "min*min", 0);
    do_start(32'h8000_0000, 32'd1, 1'b1);
    wait_over(64'hFFFF_FFFF_8000_0000, "min*1", 0);

    // Start during an op is ignored and the original operands win.
    do_start(32'd123, 32'd456, 1'b0);
    repeat (9) @(negedge clk);
    bus_if.a     = 32'd999;
    bus_if.b     = 32'd777;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_over(64'd56088, "ignore", 10);

    // Back-to-back: start while over is high.
    do_start(32'd7, 32'd6, 1'b0);
    wait_over(64'd42, "7x6", 0);
    bus_if.a     = 32'd0;
    bus_if.b     = 32'h1234_5678;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("b2b over drop", {63'd0, bus_if.over}, 64'd0);
    check("b2b busy", {63'd0, bus_if.busy}, 64'd1);
    wait_over(64'd0, "0xK", 0);

    // Abort mid-op: no over, z keeps the previous product, then a fresh op works.
    do_start(32'd100, 32'd200, 1'b0);
    repeat (14) @(negedge clk);
    bus_if.clr = 1'b1;
    @(negedge clk);
    bus_if.clr = 1'b0;
    check("clr busy", {63'd0, bus_if.busy}, 64'd0);
    check("clr z", bus_if.z, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.over) seen = 1'b1;
    end
    check("clr no over", {63'd0, seen}, 64'd0);
    $display("op clr         aborted, z=%h", bus_if.z);
    do_start(32'd100, 32'd200, 1'b0);
    wait_over(64'd20000, "post-clr", 0);

    // Asynchronous reset between edges in the middle of CALC.
    do_start(32'd11, 32'd13, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst busy", {63'd0, bus_if.busy}, 64'd0);
    check("arst over", {63'd0, bus_if.over}, 64'd0);
    check("arst z", bus_if.z, 64'd0);
    $display("op arst        z=%h busy=%b over=%b", bus_if.z, bus_if.busy, bus_if.over);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_start(32'd2, 32'd3, 1'b1);
    wait_over(64'd6, "2x3", 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_mul_seq.md
# mdu_mul_seq

Iterative 32x32 multiplier that answers the MDU controller's start/busy/over handshake, the same handshake the iterative dividers already use. It accepts one operand pair per `start`, runs a radix-2 shift-add on operand magnitudes for 32 cycles, applies the sign, and presents a 64-bit `{hi,lo}` product with a one-cycle `over` pulse. It lets the controller replace the combinational multipliers with a stalling multi-cycle path: PC is held while `busy`, and hi/lo are written on `over`.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only when `busy`=0.
- `is_signed` in 1: 1 = mult (two's complement), 0 = multu; sampled with `start`.
- `a` in 32: multiplicand (rs), sampled with `start`.
- `b` in 32: multiplier (rt), sampled with `start`.
- `clr` in 1: synchronous abort; the controller drives it when the current op is no longer a multiply.
- `z` out 64: product, `z[63:32]`→hi, `z[31:0]`→lo; valid while `over`=1, holds its value until the next completion.
- `busy` out 1: an operation is in progress.
- `over` out 1: single-cycle completion strobe.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start`=1 → CALC:
  - `mcand` = |a|, `mplr` = |b| when `is_signed`, otherwise raw a and b. Magnitudes are 32-bit unsigned, so 0x80000000 has magnitude 0x80000000.
  - `neg` = `is_signed` & (a[31]^b[31]); `prod` = 0; `cnt` = 0; `busy` = 1.
- CALC iteration, one per cycle:
  - `sum[32:0]` = {1'b0, `prod`[63:32]} + (`mplr`[0] ? `mcand` : 0).
  - `prod` = {`sum`, `prod`[31:1]}, i.e. 65 bits shifted right one to 64. `mplr` shifts right one; `cnt`++.
- After iteration 32 (`cnt`==31 at the edge) → DONE:
  - `z` = `neg` ? −`prod` : `prod` (64-bit two's complement); `over` = 1; `busy` = 0.
- DONE → IDLE next edge, `over` = 0. If `start`=1 in DONE, go straight to CALC and latch new operands; `over` still drops.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- `clr`=1 in any state → IDLE at the next edge: `busy` = 0, `over` = 0, `z` unchanged. `clr` has priority over `start`.
- Arithmetic is exact for all inputs; there is no overflow and no exception output.

## Timing
- Reset (`reset_n`=0, async): state IDLE, `busy` 0, `over` 0, `z` 0, internal registers 0. Reset mid-operation discards the operation.
- Latency:
  - `start` sampled at edge E0; `busy` high from E0.
  - Iterations occur at E1..E32; at E32 `busy` falls and `over` and `z` rise.
  - `over` is high for the cycle after E32, which is 32 cycles after the accepting edge.
- Throughput: back-to-back ops via `start` in DONE give one result per 33 cycles.
- Stall contract: controller holds PC while `start`|`busy` and releases it on `over`. `over`=1 never coincides with `busy`=1.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, `is_signed`=0 → `over` exactly 32 cycles after the `start` edge, `z`=0xFFFFFFFE00000001; `busy` high the 32 cycles before.
- Signed corners:
  - −3×5 → `z`=0xFFFFFFFFFFFFFFF1.
  - −1×−1 → `z`=0x0000000000000001.
  - 0x80000000×0x80000000 → `z`=0x4000000000000000.
  - 0x80000000×1 → `z`=0xFFFFFFFF80000000.
- Ignore/retain:
  - Pulse `start` with new operands at cycle 10 of an op → result matches the original operands.
  - `z` holds for 5 idle cycles after `over`.
- Back-to-back: 7×6 then `start` asserted during `over` with 0×0x12345678 → `z`=42, then `z`=0 after 33 further cycles; exactly two `over` pulses.
- Abort: `clr` at cycle 15 → `busy`=0 next edge, no `over`, `z` keeps the previous product; a fresh `start` then yields a correct result.
- Async reset: drop `reset_n` mid-CALC between edges → `busy`, `over`, `z` go to 0 immediately; after release, 2×3 signed gives `z`=6.
